// File: rtl/instruction_rom_responder.sv
// instruction_rom_responder
//   Responder side of the instruction-fetch interface. A request accepted on
//   inst_enable/inst_addr becomes four pipelined halfword reads of a 16-bit
//   synchronous ROM, assembled little-endian into the 64-bit inst_data word.
//
//   Parameters
//     ADDR_WIDTH   ROM halfword address width (ROM holds 2**ADDR_WIDTH halfwords)
//     ROM_LATENCY  fixed ROM read latency in cycles, 1..4
//
//   Ports
//     clock        system clock, rising edge
//     reset        synchronous active-high reset
//     inst_enable  fetch request from the instruction cache
//     inst_addr    byte address of the first byte to fetch
//     inst_data    fetched bytes, inst_data[15:0] is the halfword at inst_addr
//     inst_busy    high while the fetch is in progress
//     rom_enable   ROM read strobe (registered)
//     rom_addr     ROM halfword address (registered)
//     rom_data     ROM read data, valid ROM_LATENCY cycles after rom_enable
//
//   Optional feature (macro INST_ROM_BUFFER_EN)
//     One-entry line buffer: a request whose halfword base matches the last
//     completed fetch skips the ROM and keeps inst_data unchanged.
module instruction_rom_responder #(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned ROM_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  inst_enable,
  input  logic [63:0]           inst_addr,
  output logic [63:0]           inst_data,
  output logic                  inst_busy,
  output logic                  rom_enable,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [15:0]           rom_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state;
  logic [1:0]              issue_cnt;
  logic [1:0]              capture_cnt;
  // One bit per cycle of ROM latency: the top bit marks a returning beat.
  logic [ROM_LATENCY-1:0]  pend;
  logic [ADDR_WIDTH-1:0]   req_base;

  // Halfword base of the request; byte-offset bit and high bits are dropped.
  assign req_base = inst_addr[ADDR_WIDTH:1];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{inst_addr[63:ADDR_WIDTH+1], inst_addr[0]};

`ifdef INST_ROM_BUFFER_EN
  logic                  buf_valid;
  logic [ADDR_WIDTH-1:0] buf_tag;
  logic [ADDR_WIDTH-1:0] base;
  logic                  hit;
`endif

  // Fetch sequencer: accept, issue four beats, capture four beats, done.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      inst_busy   <= 1'b0;
      inst_data   <= '0;
      rom_enable  <= 1'b0;
      rom_addr    <= '0;
      issue_cnt   <= '0;
      capture_cnt <= '0;
      pend        <= '0;
`ifdef INST_ROM_BUFFER_EN
      buf_valid   <= 1'b0;
      buf_tag     <= '0;
      base        <= '0;
      hit         <= 1'b0;
`endif
    end else begin
      pend <= ROM_LATENCY'({pend, rom_enable});
      case (state)
        IDLE: begin
          if (inst_enable) begin
            state       <= READ;
            inst_busy   <= 1'b1;
            issue_cnt   <= '0;
            capture_cnt <= '0;
`ifdef INST_ROM_BUFFER_EN
            base <= req_base;
            if (buf_valid && (buf_tag == req_base)) begin
              hit <= 1'b1;
            end else begin
              rom_enable <= 1'b1;
              rom_addr   <= req_base;
            end
`else
            rom_enable <= 1'b1;
            rom_addr   <= req_base;
`endif
          end
        end
        READ: begin
`ifdef INST_ROM_BUFFER_EN
          // Buffer hit: one busy cycle, no ROM traffic, data untouched.
          if (hit) begin
            hit       <= 1'b0;
            state     <= DONE;
            inst_busy <= 1'b0;
          end
`endif
          // Issue side: address wraps naturally at ADDR_WIDTH bits.
          if (rom_enable) begin
            if (issue_cnt == 2'd3) begin
              rom_enable <= 1'b0;
            end else begin
              issue_cnt <= issue_cnt + 2'd1;
              rom_addr  <= rom_addr + ADDR_WIDTH'(1);
            end
          end
          // Capture side: beat k lands in halfword k.
          if (pend[ROM_LATENCY-1]) begin
            inst_data[{capture_cnt, 4'b0000} +: 16] <= rom_data;
            capture_cnt <= capture_cnt + 2'd1;
            if (capture_cnt == 2'd3) begin
              state     <= DONE;
              inst_busy <= 1'b0;
`ifdef INST_ROM_BUFFER_EN
              buf_valid <= 1'b1;
              buf_tag   <= base;
`endif
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_rom_responder.sv
// Testbench for instruction_rom_responder: two instances driven by the same
// request stream, one with default parameters and one with ADDR_WIDTH=4,
// ROM_LATENCY=3, checked against a transaction-timing reference model.
module tb_instruction_rom_responder;

  localparam int unsigned AW_A  = 16;
  localparam int unsigned LAT_A = 1;
  localparam int unsigned AW_B  = 4;
  localparam int unsigned LAT_B = 3;
`ifdef INST_ROM_BUFFER_EN
  localparam bit BUF = 1'b1;
`else
  localparam bit BUF = 1'b0;
`endif

  logic             clock       = 1'b0;
  logic             reset       = 1'b1;
  logic             inst_enable = 1'b0;
  logic [63:0]      inst_addr   = '0;

  logic [63:0]      data_a, data_b;
  logic             busy_a, busy_b, ren_a, ren_b;
  logic [AW_A-1:0]  raddr_a;
  logic [AW_B-1:0]  raddr_b;
  logic [15:0]      rdata_a, rdata_b;

  int checks   = 0;
  int failures = 0;

  // Reference model state per instance: phase = cycles since acceptance (0 = idle).
  int          lat    [2] = '{LAT_A, LAT_B};
  int          aw     [2] = '{AW_A, AW_B};
  int          m_ph   [2] = '{0, 0};
  bit          m_hit  [2] = '{1'b0, 1'b0};
  int unsigned m_base [2] = '{0, 0};
  logic [63:0] m_data [2] = '{64'h0, 64'h0};
  bit          m_bval [2] = '{1'b0, 1'b0};
  int unsigned m_btag [2] = '{0, 0};

  always #5 clock = ~clock;

  instruction_rom_responder #(.ADDR_WIDTH(AW_A), .ROM_LATENCY(LAT_A)) dut_a (
    .clock(clock), .reset(reset), .inst_enable(inst_enable), .inst_addr(inst_addr),
    .inst_data(data_a), .inst_busy(busy_a), .rom_enable(ren_a), .rom_addr(raddr_a),
    .rom_data(rdata_a)
  );

  instruction_rom_responder #(.ADDR_WIDTH(AW_B), .ROM_LATENCY(LAT_B)) dut_b (
    .clock(clock), .reset(reset), .inst_enable(inst_enable), .inst_addr(inst_addr),
    .inst_data(data_b), .inst_busy(busy_b), .rom_enable(ren_b), .rom_addr(raddr_b),
    .rom_data(rdata_b)
  );

  function automatic logic [15:0] rom_word(int unsigned h);
    return 16'(h + 32'h1000);
  endfunction

  // ROM models: garbage on the bus whenever no read was issued.
  logic [15:0] pa [LAT_A];
  logic [15:0] pb [LAT_B];
  always @(posedge clock) begin
    for (int i = LAT_A - 1; i > 0; i--) pa[i] <= pa[i-1];
    pa[0] <= ren_a ? rom_word(32'(raddr_a)) : 16'($urandom);
    for (int i = LAT_B - 1; i > 0; i--) pb[i] <= pb[i-1];
    pb[0] <= ren_b ? rom_word(32'(raddr_b)) : 16'($urandom);
  end
  assign rdata_a = pa[LAT_A-1];
  assign rdata_b = pb[LAT_B-1];

  function automatic logic [63:0] line_of(int d, int unsigned base);
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < 4; k++)
      v[16*k +: 16] = rom_word((base + 32'(k)) % (32'd1 << aw[d]));
    return v;
  endfunction

  function automatic int done_ph(int d);
    return m_hit[d] ? 2 : 5 + lat[d];
  endfunction

  task automatic model_update(input logic r, input logic e, input logic [63:0] a);
    for (int d = 0; d < 2; d++) begin
      if (r) begin
        m_ph[d] = 0; m_data[d] = '0; m_bval[d] = 1'b0; m_hit[d] = 1'b0;
      end else if (m_ph[d] == 0) begin
        if (e) begin
          m_base[d] = 32'((a >> 1) & ((64'd1 << aw[d]) - 64'd1));
          m_hit[d]  = BUF && m_bval[d] && (m_btag[d] == m_base[d]);
          m_ph[d]   = 1;
        end
      end else begin
        m_ph[d]++;
        if (m_ph[d] == done_ph(d) && !m_hit[d]) begin
          m_data[d] = line_of(d, m_base[d]);
          m_bval[d] = 1'b1;
          m_btag[d] = m_base[d];
        end
        if (m_ph[d] == done_ph(d) + 1) m_ph[d] = 0;
      end
    end
  endtask

  // Expected {busy, rom_enable, rom_addr, inst_data} and which fields are defined.
  function automatic logic [81:0] exp_vec(int d, output logic [81:0] mask);
    logic [81:0] e;
    int p;
    p    = m_ph[d];
    e    = '0;
    mask = {2'b11, 80'h0};
    e[81] = (p >= 1) && (p < done_ph(d));
    e[80] = !m_hit[d] && (p >= 1) && (p <= 4);
    if (e[80]) begin
      e[79:64]    = 16'((m_base[d] + 32'(p) - 32'd1) % (32'd1 << aw[d]));
      mask[79:64] = '1;
    end
    if (p == 0 || p == done_ph(d)) begin
      e[63:0]    = m_data[d];
      mask[63:0] = '1;
    end
    return e;
  endfunction

  function automatic logic [81:0] obs_vec(int d);
    return (d == 0) ? {busy_a, ren_a, raddr_a, data_a}
                    : {busy_b, ren_b, 12'h000, raddr_b, data_b};
  endfunction

  task automatic step();
    logic        r;
    logic        e;
    logic [63:0] a;
    r = reset; e = inst_enable; a = inst_addr;
    @(posedge clock);
    #1;
    model_update(r, e, a);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (m_ph[0] != 0 || m_ph[1] != 0); i++) step();
  endtask

  // One request, then run until both instances are idle again.
  task automatic do_fetch(input logic [63:0] a, output int ren_na, output int ren_nb,
                          output int busy_na, output int busy_nb,
                          output logic [63:0] seq_a, output logic [15:0] seq_b);
    ren_na = 0; ren_nb = 0; busy_na = 0; busy_nb = 0; seq_a = '0; seq_b = '0;
    inst_enable = 1'b1; inst_addr = a;
    step();
    inst_enable = 1'b0; inst_addr = {$urandom, $urandom};
    for (int i = 0; i < 40; i++) begin
      if (ren_a && ren_na < 4) seq_a |= 64'(raddr_a) << (16 * ren_na);
      if (ren_b && ren_nb < 4) seq_b |= 16'(raddr_b) << (4 * ren_nb);
      ren_na  += int'(ren_a);
      ren_nb  += int'(ren_b);
      busy_na += int'(busy_a);
      busy_nb += int'(busy_b);
      if (m_ph[0] == 0 && m_ph[1] == 0) break;
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; inst_enable = 1'b1; inst_addr = 64'h10;
    repeat (3) step();
    checks++;
    if ({busy_a, ren_a, raddr_a, data_a} !== '0) begin
      failures++;
      $display("FAIL reset_state_a got busy=%b ren=%b addr=%h data=%h want all zero",
               busy_a, ren_a, raddr_a, data_a);
    end
    checks++;
    if ({busy_b, ren_b, raddr_b, data_b} !== '0) begin
      failures++;
      $display("FAIL reset_state_b got busy=%b ren=%b addr=%h data=%h want all zero",
               busy_b, ren_b, raddr_b, data_b);
    end
    reset = 1'b0; inst_enable = 1'b0;
    step();
    checks++;
    if ({busy_a, busy_b} !== 2'b00) begin
      failures++;
      $display("FAIL enable_during_reset got busy_a=%b busy_b=%b want 0 0", busy_a, busy_b);
    end
  endtask

  task automatic test_fetch(input logic [63:0] a, input logic [63:0] exp_a,
                            input logic [63:0] exp_b, input logic [63:0] exp_seq_a,
                            input logic [15:0] exp_seq_b);
    int rna, rnb, bna, bnb;
    logic [63:0] sa;
    logic [15:0] sb;
    do_fetch(a, rna, rnb, bna, bnb, sa, sb);
    checks++;
    if (sa !== exp_seq_a) begin
      failures++;
      $display("FAIL fetch_addr_seq_a addr=%h got %h want %h", a, sa, exp_seq_a);
    end
    checks++;
    if (sb !== exp_seq_b) begin
      failures++;
      $display("FAIL fetch_addr_seq_b addr=%h got %h want %h", a, sb, exp_seq_b);
    end
    checks++;
    if (bna != 5 || bnb != 7) begin
      failures++;
      $display("FAIL fetch_busy_len addr=%h got a=%0d b=%0d want a=5 b=7", a, bna, bnb);
    end
    checks++;
    if (rna != 4 || rnb != 4) begin
      failures++;
      $display("FAIL fetch_rom_reads addr=%h got a=%0d b=%0d want 4 4", a, rna, rnb);
    end
    checks++;
    if (data_a !== exp_a) begin
      failures++;
      $display("FAIL fetch_data_a addr=%h got %h want %h", a, data_a, exp_a);
    end
    checks++;
    if (data_b !== exp_b) begin
      failures++;
      $display("FAIL fetch_data_b addr=%h got %h want %h", a, data_b, exp_b);
    end
  endtask

  task automatic test_held_enable();
    logic [63:0] rises_a, rises_b, want_a, want_b;
    logic        pa_busy, pb_busy;
    reset = 1'b1; step(); reset = 1'b0; step();
    rises_a = '0; rises_b = '0;
    pa_busy = busy_a; pb_busy = busy_b;
    inst_enable = 1'b1; inst_addr = {$urandom, $urandom};
    for (int i = 1; i <= 20; i++) begin
      step();
      if (busy_a && !pa_busy) rises_a = (rises_a << 8) | 64'(i);
      if (busy_b && !pb_busy) rises_b = (rises_b << 8) | 64'(i);
      pa_busy = busy_a; pb_busy = busy_b;
      if (i == 20) inst_enable = 1'b0;
    end
    want_a = BUF ? 64'h01_08_0B_0E_11_14 : 64'h01_08_0F;
    want_b = BUF ? 64'h01_0A_0D_10_13    : 64'h01_0A_13;
    checks++;
    if (rises_a !== want_a) begin
      failures++;
      $display("FAIL held_accept_cycles_a got %h want %h", rises_a, want_a);
    end
    checks++;
    if (rises_b !== want_b) begin
      failures++;
      $display("FAIL held_accept_cycles_b got %h want %h", rises_b, want_b);
    end
    drain();
  endtask

  task automatic test_reset_midfetch();
    int rna, rnb, bna, bnb;
    logic [63:0] sa;
    logic [15:0] sb;
    inst_enable = 1'b1; inst_addr = 64'h10;
    step();
    inst_enable = 1'b0;
    step(); step();
    reset = 1'b1;
    step();
    checks++;
    if ({busy_a, ren_a, data_a, busy_b, ren_b, data_b} !== '0) begin
      failures++;
      $display("FAIL midfetch_abort got a:busy=%b ren=%b data=%h b:busy=%b ren=%b data=%h want zeros",
               busy_a, ren_a, data_a, busy_b, ren_b, data_b);
    end
    reset = 1'b0;
    step();
    do_fetch(64'h18, rna, rnb, bna, bnb, sa, sb);
    checks++;
    if (data_a !== 64'h100F_100E_100D_100C || data_b !== 64'h100F_100E_100D_100C) begin
      failures++;
      $display("FAIL midfetch_recover got a=%h b=%h want 100f100e100d100c", data_a, data_b);
    end
  endtask

  task automatic test_buffer();
    int rna, rnb, bna, bnb;
    logic [63:0] sa;
    logic [15:0] sb;
    do_fetch(64'h10, rna, rnb, bna, bnb, sa, sb);
    do_fetch(64'h10, rna, rnb, bna, bnb, sa, sb);
    checks++;
    if (rna != (BUF ? 0 : 4) || rnb != (BUF ? 0 : 4)) begin
      failures++;
      $display("FAIL buffer_repeat_reads got a=%0d b=%0d want %0d", rna, rnb, BUF ? 0 : 4);
    end
    checks++;
    if (bna != (BUF ? 1 : 5) || bnb != (BUF ? 1 : 7)) begin
      failures++;
      $display("FAIL buffer_repeat_busy got a=%0d b=%0d want %0d %0d",
               bna, bnb, BUF ? 1 : 5, BUF ? 1 : 7);
    end
    checks++;
    if (data_a !== 64'h100B_100A_1009_1008 || data_b !== 64'h100B_100A_1009_1008) begin
      failures++;
      $display("FAIL buffer_repeat_data got a=%h b=%h want 100b100a10091008", data_a, data_b);
    end
    do_fetch(64'h18, rna, rnb, bna, bnb, sa, sb);
    checks++;
    if (rna != 4 || rnb != 4 || bna != 5 || bnb != 7) begin
      failures++;
      $display("FAIL buffer_new_line got reads=%0d/%0d busy=%0d/%0d want 4/4 5/7",
               rna, rnb, bna, bnb);
    end
    checks++;
    if (data_a !== 64'h100F_100E_100D_100C) begin
      failures++;
      $display("FAIL buffer_new_data got %h want 100f100e100d100c", data_a);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      reset       = ($urandom_range(0, 63) == 0);
      inst_enable = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       inst_addr = 64'h10;
        1:       inst_addr = 64'h12;
        2:       inst_addr = 64'h1D;
        default: inst_addr = {$urandom, $urandom};
      endcase
      step();
      for (int d = 0; d < 2; d++) begin
        logic [81:0] m, e, o;
        e = exp_vec(d, m);
        o = obs_vec(d);
        checks++;
        if ((o & m) !== (e & m)) begin
          failures++;
          $display("FAIL random_cycle dut%0d i=%0d got busy=%b ren=%b addr=%h data=%h want busy=%b ren=%b addr=%h data=%h mask=%h",
                   d, i, o[81], o[80], o[79:64], o[63:0], e[81], e[80], e[79:64], e[63:0], m);
        end
      end
    end
    reset = 1'b0; inst_enable = 1'b0;
    drain();
  endtask

  initial begin
    test_reset();
    test_fetch(64'h10, 64'h100B_100A_1009_1008, 64'h100B_100A_1009_1008,
               64'h000B_000A_0009_0008, 16'hBA98);
    drain();
    test_fetch(64'h1D, 64'h1011_1010_100F_100E, 64'h1001_1000_100F_100E,
               64'h0011_0010_000F_000E, 16'h10FE);
    drain();
    test_held_enable();
    test_reset_midfetch();
    drain();
    test_buffer();
    drain();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
